// File: rtl/sprite_compositor_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_compositor_if
//  Brief    : Pixel request/response bundle between the OLED pixel scanner
//             (master) and the sprite compositor (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface sprite_compositor_if;
    logic        pix_req;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;
    logic        pix_ready;
    logic        pix_valid;
    logic [15:0] pix_rgb;

    modport master (
        output pix_req, pix_x, pix_y,
        input  pix_ready, pix_valid, pix_rgb
    );

    modport slave (
        input  pix_req, pix_x, pix_y,
        output pix_ready, pix_valid, pix_rgb
    );
endinterface
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_compositor
//  Brief    : Per-pixel layer compositor. Translates a screen pixel into
//             sprite-local BRAM coordinates, waits out the registered BRAM
//             read and resolves game-over / projectile / character /
//             background priority with transparency into one RGB565 pixel.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_compositor #(
    parameter int          N_CHAR = 4,
    parameter int          N_PROJ = 4,
    parameter int          SPR_W  = 20,
    parameter logic [1:0]  TRANSP = 2'b01,
    localparam int         NS     = N_CHAR + N_PROJ
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    sprite_compositor_if.slave     pix,
    input  wire logic [NS-1:0]     i_spr_act,
    input  wire logic [NS*7-1:0]   i_spr_px,
    input  wire logic [NS*6-1:0]   i_spr_py,
    input  wire logic [NS*2-1:0]   i_spr_dir_in,
    input  wire logic              i_game_over,
    output logic [NS*10-1:0]       o_spr_x,
    output logic [NS*10-1:0]       o_spr_y,
    output logic [NS*2-1:0]        o_spr_dir,
    input  wire logic [NS*18-1:0]  i_spr_pixel,
    output logic [9:0]             o_bg_x,
    output logic [9:0]             o_bg_y,
    input  wire logic [17:0]       i_bg_pixel,
    output logic [9:0]             o_go_x,
    output logic [9:0]             o_go_y,
    input  wire logic [17:0]       i_go_pixel
);

    localparam logic [9:0] c_SPR_W = 10'(SPR_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;

    logic [NS*10-1:0]  w_lx;
    logic [NS*10-1:0]  w_ly;
    logic [NS-1:0]     w_hit;

    // Registers below are the per-pixel snapshot: everything the in-flight
    // pixel needs is captured at accept, so later input changes are harmless.
    logic [NS*10-1:0]  r_spr_x;
    logic [NS*10-1:0]  r_spr_y;
    logic [NS*2-1:0]   r_spr_dir;
    logic [NS-1:0]     r_hit;
    logic              r_go;
    logic [9:0]        r_px10;
    logic [9:0]        r_py10;
    logic [15:0]       r_rgb;
    logic [15:0]       w_rgb;

    // Background and game-over layers are always opaque; their flag bits
    // carry no meaning here.
    logic              w_unused;
    assign w_unused = ^{i_bg_pixel[1:0], i_go_pixel[1:0]};

    // Sprite-local coordinates; a pixel left/above the sprite wraps to a
    // large value and therefore fails the bounds compare naturally.
    for (genvar g = 0; g < NS; g++) begin : g_slot
        assign w_lx[10*g +: 10] = {3'b000, pix.pix_x} - {3'b000, i_spr_px[7*g +: 7]};
        assign w_ly[10*g +: 10] = {4'b0000, pix.pix_y} - {4'b0000, i_spr_py[6*g +: 6]};
        assign w_hit[g] = i_spr_act[g]
                        && (w_lx[10*g +: 10] < c_SPR_W)
                        && (w_ly[10*g +: 10] < c_SPR_W);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: one cycle per state, requests only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pix.pix_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR:  w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Priority resolve over BRAM data: lowest index wins inside a class,
    // so iterate downward and let later matches override earlier ones.
    always_comb begin
        w_rgb = i_bg_pixel[17:2];
        for (int c = N_CHAR - 1; c >= 0; c--) begin
            if (r_hit[c] && (i_spr_pixel[18*c +: 2] != TRANSP)) begin
                w_rgb = i_spr_pixel[18*c + 2 +: 16];
            end
        end
        for (int p = NS - 1; p >= N_CHAR; p--) begin
            if (r_hit[p] && (i_spr_pixel[18*p +: 2] != TRANSP)) begin
                w_rgb = i_spr_pixel[18*p + 2 +: 16];
            end
        end
        if (r_go) begin
            w_rgb = i_go_pixel[17:2];
        end
    end

    // Coordinates are registered at accept so the BRAMs see them throughout
    // ADDR and return data during READ; the colour is captured leaving READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spr_x   <= '0;
            r_spr_y   <= '0;
            r_spr_dir <= '0;
            r_hit     <= '0;
            r_go      <= 1'b0;
            r_px10    <= '0;
            r_py10    <= '0;
            r_rgb     <= '0;
        end else begin
            if (w_accept) begin
                r_spr_x   <= w_lx;
                r_spr_y   <= w_ly;
                r_spr_dir <= i_spr_dir_in;
                r_hit     <= w_hit;
                r_go      <= i_game_over;
                r_px10    <= {3'b000, pix.pix_x};
                r_py10    <= {4'b0000, pix.pix_y};
            end
            if (r_state == S_READ) begin
                r_rgb <= w_rgb;
            end
        end
    end

    assign o_spr_x       = r_spr_x;
    assign o_spr_y       = r_spr_y;
    assign o_spr_dir     = r_spr_dir;
    assign o_bg_x        = r_px10;
    assign o_bg_y        = r_py10;
    assign o_go_x        = r_px10;
    assign o_go_y        = r_py10;
    assign pix.pix_ready = (r_state == S_IDLE);
    assign pix.pix_valid = (r_state == S_DONE);
    assign pix.pix_rgb   = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_compositor
//  Brief    : Self-checking bench for sprite_compositor with behavioural
//             BRAM models and a rule-level reference compositor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_compositor;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;

    logic [7:0]   act;
    logic [55:0]  spx;
    logic [47:0]  spy;
    logic [15:0]  sdir;
    logic         go;
    logic [79:0]  spr_x, spr_y;
    logic [15:0]  spr_dir;
    logic [143:0] spr_pixel;
    logic [9:0]   bg_x, bg_y, go_x, go_y;
    logic [17:0]  bg_pixel, go_pixel;

    logic [15:0]  col [8];
    logic [1:0]   flg [8];
    logic [15:0]  bg_col, go_col;
    logic [1:0]   bg_flg, go_flg;
    bit           mix;

    int total = 0;
    int bad   = 0;

    sprite_compositor_if pif ();

    sprite_compositor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix          (pif),
        .i_spr_act    (act),
        .i_spr_px     (spx),
        .i_spr_py     (spy),
        .i_spr_dir_in (sdir),
        .i_game_over  (go),
        .o_spr_x      (spr_x),
        .o_spr_y      (spr_y),
        .o_spr_dir    (spr_dir),
        .i_spr_pixel  (spr_pixel),
        .o_bg_x       (bg_x),
        .o_bg_y       (bg_y),
        .i_bg_pixel   (bg_pixel),
        .o_go_x       (go_x),
        .o_go_y       (go_y),
        .i_go_pixel   (go_pixel)
    );

    always #5 clk = ~clk;

    // BRAM contents: a base colour per layer, optionally mixed with the
    // local address so wrong coordinates produce wrong colours.
    function automatic logic [17:0] spr_word(int i, logic [9:0] x, logic [9:0] y, logic [1:0] d);
        logic [15:0] c;
        c = col[i];
        if (mix) c = c ^ 16'(x * 37 + y * 709 + d * 4099 + i * 517);
        return {c, flg[i]};
    endfunction

    function automatic logic [17:0] bg_word(logic [9:0] x, logic [9:0] y);
        return {bg_col ^ (mix ? 16'(x * 13 + y * 401) : 16'h0), bg_flg};
    endfunction

    function automatic logic [17:0] go_word(logic [9:0] x, logic [9:0] y);
        return {go_col ^ (mix ? 16'(x * 29 + y * 173) : 16'h0), go_flg};
    endfunction

    // Registered-read BRAMs (1-cycle latency).
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            spr_pixel[18*i +: 18] <= spr_word(i, spr_x[10*i +: 10], spr_y[10*i +: 10], spr_dir[2*i +: 2]);
        bg_pixel <= bg_word(bg_x, bg_y);
        go_pixel <= go_word(go_x, go_y);
    end

    // Reference: game over, then projectiles, then characters, then background.
    function automatic logic [15:0] model(logic [6:0] x, logic [5:0] y);
        logic [17:0] w;
        int lx, ly;
        if (go) begin
            w = go_word(10'(x), 10'(y));
            return w[17:2];
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i  = (pass == 0) ? 4 + k : k;
                lx = int'(x) - int'(spx[7*i +: 7]);
                ly = int'(y) - int'(spy[6*i +: 6]);
                if (act[i] && lx >= 0 && lx < 20 && ly >= 0 && ly < 20) begin
                    w = spr_word(i, 10'(lx), 10'(ly), sdir[2*i +: 2]);
                    if (w[1:0] != 2'b01) return w[17:2];
                end
            end
        end
        w = bg_word(10'(x), 10'(y));
        return w[17:2];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (pif.pix_ready !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Issue one pixel, optionally scramble the sprite inputs after accept,
    // then check latency and colour.
    task automatic pixel(input logic [6:0] x, input logic [5:0] y, input string tag,
                         input logic [15:0] exp, input bit scr);
        int lat;
        pif.pix_x   = x;
        pif.pix_y   = y;
        pif.pix_req = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        pif.pix_req = 1'b0;
        if (scr) begin
            act  = 8'($urandom);
            spx  = {$urandom, $urandom};
            spy  = {$urandom, $urandom};
            sdir = 16'($urandom);
            go   = 1'($urandom);
            pif.pix_x = 7'($urandom);
        end
        lat = 1;
        while (pif.pix_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'd3);
        chk(tag, 128'(pif.pix_rgb), 128'(exp));
    endtask

    initial begin
        int nv;
        logic [6:0] rx;
        logic [5:0] ry;
        int t;

        pif.pix_req = 1'b0;
        pif.pix_x   = '0;
        pif.pix_y   = '0;
        act = '0; spx = '0; spy = '0; sdir = '0; go = 1'b0;
        for (int i = 0; i < 8; i++) begin
            col[i] = '0;
            flg[i] = '0;
        end
        bg_col = 16'h1234; bg_flg = 2'b00;
        go_col = 16'h0000; go_flg = 2'b00;
        mix = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'(pif.pix_ready), 128'd1);
        chk("rst_valid", 128'(pif.pix_valid), 128'd0);
        chk("rst_rgb",   128'(pif.pix_rgb),   128'd0);
        chk("rst_sprx",  128'(spr_x), 128'd0);
        chk("rst_spry",  128'(spr_y), 128'd0);
        chk("rst_misc",  128'({spr_dir, bg_x, bg_y, go_x, go_y}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Background only
        pixel(7'd5, 6'd5, "bg", 16'h1234, 1'b0);
        chk("bg_xy", 128'({bg_x, bg_y, go_x, go_y}), 128'({10'd5, 10'd5, 10'd5, 10'd5}));

        // Character hit, opaque then transparent
        act = 8'b0000_0001; spx[6:0] = 7'd10; spy[5:0] = 6'd10;
        col[0] = 16'hF800; flg[0] = 2'b00;
        pixel(7'd15, 6'd12, "char", 16'hF800, 1'b0);
        chk("char_local", 128'({spr_x[9:0], spr_y[9:0]}), 128'({10'd5, 10'd2}));
        flg[0] = 2'b01;
        pixel(7'd15, 6'd12, "char_tr", 16'h1234, 1'b0);

        // Priority between classes
        act = 8'b0001_0010;
        spx = '0; spy = '0;
        spx[13:7] = 7'd2;  spy[11:6]  = 6'd3;
        spx[34:28] = 7'd2; spy[29:24] = 6'd3;
        col[1] = 16'h07E0; flg[1] = 2'b00;
        col[4] = 16'h001F; flg[4] = 2'b00;
        pixel(7'd10, 6'd10, "prio_proj", 16'h001F, 1'b0);
        flg[4] = 2'b01;
        pixel(7'd10, 6'd10, "prio_char", 16'h07E0, 1'b0);
        act = 8'b0101_1010;
        spx[27:21] = 7'd2; spy[23:18] = 6'd3;
        spx[48:42] = 7'd2; spy[41:36] = 6'd3;
        col[3] = 16'h5555; flg[3] = 2'b00;
        col[6] = 16'hAAAA; flg[6] = 2'b00;
        pixel(7'd10, 6'd10, "prio_proj6", 16'hAAAA, 1'b0);
        flg[6] = 2'b01;
        pixel(7'd10, 6'd10, "prio_char1", 16'h07E0, 1'b0);

        // Bounds / wrap at the screen corner
        act = 8'b0000_0100;
        spx[20:14] = 7'd90; spy[17:12] = 6'd60;
        col[2] = 16'h7777; flg[2] = 2'b00;
        pixel(7'd89, 6'd60, "wrap", 16'h1234, 1'b0);
        chk("wrap_x", 128'(spr_x[29:20]), 128'd1023);
        pixel(7'd95, 6'd63, "corner", 16'h7777, 1'b0);
        chk("corner_local", 128'({spr_x[29:20], spr_y[29:20]}), 128'({10'd5, 10'd3}));

        // Game over overrides everything
        act = 8'hFF; spx = '0; spy = '0;
        for (int i = 0; i < 8; i++) flg[i] = 2'b00;
        go = 1'b1; go_col = 16'hABCD; go_flg = 2'b01;
        pixel(7'd3, 6'd3, "gameover", 16'hABCD, 1'b0);
        go = 1'b0;

        // Busy: a request during READ is ignored
        act = '0;
        wait_idle();
        pif.pix_x = 7'd7; pif.pix_y = 6'd8; pif.pix_req = 1'b1;
        @(posedge clk); #1;
        pif.pix_req = 1'b0;
        @(posedge clk); #1;
        pif.pix_x = 7'd50; pif.pix_y = 6'd40; pif.pix_req = 1'b1;
        @(posedge clk); #1;
        pif.pix_req = 1'b0;
        nv = (pif.pix_valid === 1'b1) ? 1 : 0;
        chk("busy_rgb", 128'(pif.pix_rgb), 128'h1234);
        repeat (7) begin
            @(posedge clk); #1;
            if (pif.pix_valid === 1'b1) nv++;
        end
        chk("busy_nvalid", 128'(nv), 128'd1);
        chk("busy_bgx", 128'(bg_x), 128'd7);

        // Reset pulse while in READ drops the pixel
        pif.pix_x = 7'd20; pif.pix_y = 6'd20; pif.pix_req = 1'b1;
        @(posedge clk); #1;
        pif.pix_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstread_ready", 128'(pif.pix_ready), 128'd1);
        chk("rstread_valid", 128'(pif.pix_valid), 128'd0);
        chk("rstread_rgb",   128'(pif.pix_rgb),   128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (pif.pix_valid === 1'b1) nv++;
        end
        chk("rstread_nvalid", 128'(nv), 128'd0);

        // Randomised pixels against the reference model
        mix = 1'b1;
        repeat (80) begin
            rx = 7'($urandom_range(0, 95));
            ry = 6'($urandom_range(0, 63));
            act  = 8'($urandom);
            sdir = 16'($urandom);
            go   = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 8; i++) begin
                t = int'(rx) - int'($urandom_range(0, 25));
                if (t < 0) t = 0;
                spx[7*i +: 7] = 7'(t);
                t = int'(ry) - int'($urandom_range(0, 25));
                if (t < 0) t = 0;
                spy[6*i +: 6] = 6'(t);
                col[i] = 16'($urandom);
                flg[i] = 2'($urandom);
            end
            bg_col = 16'($urandom); bg_flg = 2'($urandom);
            go_col = 16'($urandom); go_flg = 2'($urandom);
            pixel(rx, ry, "rand", model(rx, ry), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
